// File: rtl/uart_frame_rx_pkg.sv
// Shared constants and byte-FSM encoding for the 8N1 UART frame receiver.
package uart_frame_rx_pkg;

  localparam int FRAME_BYTES          = 4;
  localparam int IDX_W                = $clog2(FRAME_BYTES);
  localparam int DEFAULT_CLKS_PER_BIT = 104;  // 12 MHz / 115200 baud
  localparam int TIMEOUT_BIT_TIMES    = 20;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, start/data/stop FSM, bit and baud counters.
module uart_rx_byte
  import uart_frame_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       stop_err_o,
  output logic       rx_idle_o
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

  logic [1:0]        sync_q;
  logic              rx_s;
  logic [1:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
    end
  end

  assign rx_s = sync_q[1];

  always_comb begin
    // NOTE: defaults first so no branch leaves a _d unassigned and infers a latch.
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (baud_q == HALF_LAST) begin
          baud_d  = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      ST_STOP: begin
        // Leave on the stop sample itself so a back-to-back start bit is not missed.
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          state_d = ST_IDLE;
          valid_d = rx_s;
          err_d   = !rx_s;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign stop_err_o   = err_q;
  // Drops already in the start-detection cycle, so a coincident gap timeout loses.
  assign rx_idle_o    = (state_q == ST_IDLE) && rx_s;

endmodule

// File: rtl/uart_frame_rx.sv
// Assembles four UART bytes (LSB first) into a 32-bit word with gap timeout and error pulses.
module uart_frame_rx
  import uart_frame_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int TIMEOUT_CLKS = TIMEOUT_BIT_TIMES * CLKS_PER_BIT
) (
  input  logic        Clk,
  input  logic        rst,
  input  logic        i_uart_rx,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_frame_err,
  output logic        o_timeout,
  output logic        o_busy
);

  localparam int               WORD_W   = 8 * FRAME_BYTES;
  localparam int               TMO_W    = $clog2(TIMEOUT_CLKS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [7:0]        rx_byte;
  logic              byte_valid;
  logic              stop_err;
  logic              rx_idle;
  logic              tmo_run;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              tmo_q, tmo_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk         (Clk),
    .rst_n       (rst),
    .rx_i        (i_uart_rx),
    .byte_o      (rx_byte),
    .byte_valid_o(byte_valid),
    .stop_err_o  (stop_err),
    .rx_idle_o   (rx_idle)
  );

  assign tmo_run = (idx_q != '0) && rx_idle;

  always_comb begin
    idx_d     = idx_q;
    word_d    = word_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    tmo_d     = 1'b0;
    tmo_cnt_d = tmo_cnt_q;

    if (!tmo_run) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TMO_LAST) begin
      tmo_cnt_d = '0;
      idx_d     = '0;
      tmo_d     = 1'b1;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TMO_ONE;
    end

    // A stop error on the last byte drops the whole frame, so it outranks acceptance.
    if (stop_err) begin
      idx_d  = '0;
      ferr_d = 1'b1;
    end else if (byte_valid) begin
      word_d[{idx_q, 3'b000} +: 8] = rx_byte;
      if (idx_q == LAST_IDX) begin
        data_d  = word_d;
        valid_d = 1'b1;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IDX_ONE;
      end
    end
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      idx_q     <= '0;
      // NOTE: the assembly register is reset like any other flop; stale bytes must never leak into o_data.
      word_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      tmo_q     <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      idx_q     <= idx_d;
      word_q    <= word_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      tmo_q     <= tmo_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_timeout   = tmo_q;
  assign o_busy      = !rx_idle || (idx_q != '0);

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Receive-side counterpart of the 32-bit UART telemetry path: deserialises 8N1 UART bytes from the host and assembles each group of four bytes, least-significant byte first, into one 32-bit word. Downstream logic uses the word to load setpoints or gains: upper half `[31:16]` and lower half `[15:0]`, mirroring the transmit framing. Runs on the 12 MHz PLL clock `Clk`. Sits between the board RX pin and the PID/setpoint registers.

## Interface
- `CLKS_PER_BIT`, 104, `Clk` cycles per UART bit (12 MHz / 115200).
- `TIMEOUT_CLKS`, 20 × `CLKS_PER_BIT`, maximum idle gap between bytes inside one frame.
- `Clk`  in  1  system clock, 12 MHz; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_uart_rx`  in  1  asynchronous serial input; idles high.
- `o_data`  out  32  last complete frame; byte0 is `[7:0]` … byte3 is `[31:24]`.
- `o_valid`  out  1  one-cycle pulse when `o_data` updates.
- `o_frame_err`  out  1  one-cycle pulse when a stop bit is sampled low.
- `o_timeout`  out  1  one-cycle pulse when a partial frame is discarded on gap.
- `o_busy`  out  1  high while a byte is being received or a frame is partially assembled.

## Operation
- `i_uart_rx` passes through a 2-flop synchroniser, reset value 1; all decisions use the synchronised signal.
- Byte FSM states:
  - IDLE: a synchronised low moves to START and clears the bit counter.
  - START: waits `CLKS_PER_BIT/2` cycles (integer division), then resamples.
    - Still low: go to DATA.
    - High: false start; return to IDLE with no error.
  - DATA: samples 8 bits, LSB first, each `CLKS_PER_BIT` cycles after the previous sample, then goes to STOP.
  - STOP: samples once after `CLKS_PER_BIT` cycles.
    - High: byte accepted.
    - Low: `o_frame_err` pulses, the partial frame and byte index are discarded, the byte is dropped.
    - Either way: return to IDLE on the next cycle; no wait for the full stop bit.
- Frame assembler:
  - Each accepted byte is written into shift register slot `byte_idx` (2 bits, 0..3).
  - Accepting byte 3 copies the assembled word to `o_data`, pulses `o_valid`, and wraps `byte_idx` to 0.
- Inter-byte timeout:
  - Counter runs only while `byte_idx != 0` and the FSM is in IDLE; it clears on any start detection.
  - Reaching `TIMEOUT_CLKS` sets `byte_idx` to 0 and pulses `o_timeout`; `o_data` is untouched.
- Simultaneous events:
  - Timeout expiry in the same cycle as a start detection: the start wins; no timeout.
  - A frame error on byte 3: no `o_valid`.
- `o_busy` = (FSM != IDLE) OR (`byte_idx != 0`).

## Timing
- Reset values: `o_data` = 0, `o_valid` = 0, `o_frame_err` = 0, `o_timeout` = 0, `o_busy` = 0; FSM in IDLE; `byte_idx` = 0.
- Reset mid-byte or mid-frame: everything returns immediately to the reset values; the next falling edge after `rst` deasserts starts a fresh frame.
- Start detection: 2 cycles after the pin's falling edge, from the synchroniser.
- Sample points:
  - Data bit n: (pin falling edge) + 2 + `CLKS_PER_BIT/2` + (n+1)·`CLKS_PER_BIT` cycles.
  - Stop bit: the same formula with n = 8.
- `o_valid` asserts 1 cycle after the stop-bit sample of byte 3; `o_data` is stable from that cycle until the next `o_valid`.
- All pulse outputs are registered and exactly one cycle wide.
- Back-to-back bytes with zero idle time are supported. Baud mismatch tolerance: ±2 %.

## Structure
- Shared package holds:
  - `FRAME_BYTES` = 4.
  - Byte-FSM state encoding: IDLE, START, DATA, STOP.
  - Default `CLKS_PER_BIT` for the 12 MHz clock.
- Natural sub-module `uart_rx_byte`:
  - Contains the synchroniser, the byte FSM, the bit counter and the baud counter.
  - Outputs: `byte`, `byte_valid`, `stop_err`, `rx_idle`.
- The parent `uart_frame_rx` contains the byte index, shift register, timeout counter and output registers.

## Test plan
- Bytes 0x78, 0x56, 0x34, 0x12, back-to-back at 115200 -> one `o_valid` pulse, `o_data` = 0x12345678, `o_busy` low one cycle after `o_valid`.
- Low glitch of 30 cycles on an idle line -> FSM returns to IDLE, no pulses, `o_data` unchanged.
- Bytes 0xAA, 0xBB, then byte 0xCC with its stop bit forced low -> `o_frame_err` pulses once, no `o_valid`. Following 0x01, 0x02, 0x03, 0x04 -> `o_data` = 0x04030201.
- Two bytes, then idle 25 bit-times -> `o_timeout` pulses after `TIMEOUT_CLKS` idle cycles. Next four bytes 0xEF, 0xBE, 0xAD, 0xDE -> `o_data` = 0xDEADBEEF.
- `rst` asserted in the middle of byte 2 -> all outputs 0 on the same edge. After release, a full frame of 0x11, 0x22, 0x33, 0x44 -> `o_data` = 0x44332211.
- Sender baud skewed +2 % and −2 %, 100 random frames -> every frame received correctly, no errors.
